// File: rtl/segment_pkg.sv
// segment_pkg: shared FSM states and BCD digit constants for the display encode path.
package segment_pkg;
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;
    localparam int BCD_NIBBLE_W = 4;
    localparam int SEG_DIGITS_DEFAULT = 3;
endpackage

// File: rtl/bin_to_bcd_serial_if.sv
// bin_to_bcd_serial_if: valid/ready input word and held BCD result bundle.
interface bin_to_bcd_serial_if
    import segment_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DIGITS = SEG_DIGITS_DEFAULT
);
    logic                           in_valid;
    logic                           in_ready;
    logic [DATA_W-1:0]              in_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [BCD_NIBBLE_W*DIGITS-1:0] bcd;
    logic                           overflow;
    logic [DIGITS-1:0]              blank;
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, bcd, overflow, blank
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, bcd, overflow, blank
    );
endinterface

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble digit correction, adds 3 to a BCD nibble >= 5.
module bcd_digit_adj
    import segment_pkg::*;
(
    input  logic [BCD_NIBBLE_W-1:0] d_i,
    output logic [BCD_NIBBLE_W-1:0] d_o
);
    assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bin_to_bcd_serial.sv
// bin_to_bcd_serial: sequential shift-add-3 binary to BCD converter with held result.
// Optional leading-zero blank mask under BCD_LEADING_BLANK_EN.
module bin_to_bcd_serial
    import segment_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DIGITS = SEG_DIGITS_DEFAULT
)(
    input logic                clk_i,
    input logic                rst_ni,
    bin_to_bcd_serial_if.slave bus
);
    localparam int BW = BCD_NIBBLE_W * DIGITS;
    localparam int CW = $clog2(DATA_W);

    state_e            state_q;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BW-1:0]     work_q, work_adj, work_d, bcd_q;
    logic [CW-1:0]     cnt_q;
    logic              ovf_acc_q, ovf_acc_d, ovf_q, in_ready_q, out_valid_q;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i(work_q[i*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
            .d_o(work_adj[i*BCD_NIBBLE_W +: BCD_NIBBLE_W])
        );
    end

    assign {work_d, shift_d} = {work_adj, shift_q} << 1;
    // the carry out of the top digit means the value has reached 10^DIGITS
    assign ovf_acc_d = ovf_acc_q | work_adj[BW-1];

`ifdef BCD_LEADING_BLANK_EN
    logic [DIGITS-1:0] blank_d, blank_q;
    always_comb begin
        blank_d = '0;
        for (int i = 1; i < DIGITS; i++)
            blank_d[i] = ((work_d >> (i*BCD_NIBBLE_W)) == '0);
    end
    assign bus.blank = blank_q;
`else
    assign bus.blank = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            work_q      <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            ovf_acc_q   <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef BCD_LEADING_BLANK_EN
            blank_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    shift_q    <= bus.in_data;
                    work_q     <= '0;
                    ovf_acc_q  <= 1'b0;
                    cnt_q      <= CW'(DATA_W - 1);
                    in_ready_q <= 1'b0;
                    state_q    <= CONV;
                end
                CONV: begin
                    shift_q   <= shift_d;
                    work_q    <= work_d;
                    ovf_acc_q <= ovf_acc_d;
                    if (cnt_q == '0) begin
                        bcd_q       <= work_d;
                        ovf_q       <= ovf_acc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
`ifdef BCD_LEADING_BLANK_EN
                        blank_q     <= blank_d;
`endif
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.bcd       = bcd_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: doc/bin_to_bcd_serial.md
Name: bin_to_bcd_serial

Overview:
- Sequential shift-add-3 (double-dabble) converter that turns a binary word from the RV32I core into packed BCD digits.
- Produces the per-digit nibbles consumed by the 7-segment display decoders; it is the encoding side that feeds the segment decode path.
- Valid/ready on both sides. The last result is held stable for the displays.

Parameters:
- DATA_W, 32, width of binary input word.
- DIGITS, 3, number of BCD digits produced. Each digit is 4 bits.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  converter idle, can accept.
- in_data  in  DATA_W  unsigned binary value.
- out_valid  out  1  conversion result available.
- out_ready  in  1  consumer accepts result.
- bcd  out  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0].
- overflow  out  1  input was >= 10^DIGITS.
- blank  out  DIGITS  leading-zero blank mask, one bit per digit. Only meaningful with the optional feature.

Behaviour:
- Reset (reset=0, async): state IDLE; in_ready=1; out_valid=0; bcd=0; overflow=0; blank=0; working registers and bit counter cleared.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready at an edge: load in_data into the shift register, clear the working BCD register and overflow accumulator, set counter=DATA_W-1, go to CONV.
  - CONV: in_ready=0. Each cycle:
    - add 3 to every working digit >= 5;
    - shift {bcd_work, shift_reg} left by one;
    - OR the bit leaving the top digit into the overflow accumulator;
    - decrement the counter.
    - On the edge where counter==0: copy bcd_work/overflow (post-shift) into the bcd/overflow output registers, go to DONE.
  - DONE: out_valid=1. On out_ready=1 at an edge: go to IDLE, out_valid=0 next cycle.
- Latency: out_valid rises exactly DATA_W clock edges after the accepting edge. Throughput is one word per DATA_W+2 cycles minimum.
- bcd, overflow and blank change only on the CONV->DONE edge and otherwise hold their last result through IDLE/CONV. Displays never see intermediate values.
- Overflow: bcd = value mod 10^DIGITS; overflow=1 iff value >= 10^DIGITS.
- in_valid while not IDLE: ignored, no capture. in_data need only be stable on the accepting edge.
- out_ready while not DONE: ignored.
- out_ready held high constantly: DONE lasts exactly one cycle.
- Reset mid-CONV or in DONE: immediate return to reset values. The in-flight conversion is discarded and the previous result is cleared.
- Counter width: clog2(DATA_W). No wrap; the counter is reloaded only in IDLE.

Optional Feature:
- Macro: BCD_LEADING_BLANK_EN.
- Defined: blank[i]=1 when digit i and all higher digits are 0, for i>=1. blank[0] is always 0, so value 0 displays "0". The mask is registered with bcd on the CONV->DONE edge.
- Undefined: blank is constant 0 and no blank logic is synthesised.

Decomposition:
- Shared package segment_pkg holds:
  - the FSM state enum {IDLE, CONV, DONE};
  - constant BCD_NIBBLE_W=4;
  - constant SEG_DIGITS_DEFAULT=3, also used by the display top.
- One sub-module, bcd_digit_adj: combinational 4-bit "if >=5 then +3", instantiated DIGITS times in a generate loop.

Test Plan:
- Reset, then in_data=0 accepted -> out_valid after exactly 32 edges; bcd=12'h000, overflow=0, blank=3'b110 (macro on) / 3'b000 (macro off).
- in_data=255 -> bcd=12'h255, overflow=0; then in_data=999 -> bcd=12'h999, overflow=0, blank=3'b000.
- in_data=1000 -> bcd=12'h000, overflow=1; in_data=32'hFFFF_FFFF -> bcd=12'h295, overflow=1.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and in_data changing -> out_valid and bcd stable, in_ready=0, no new capture. Release out_ready -> in_ready=1 the next cycle.
- Convert 7 (bcd=12'h007), then start 42 and pulse reset low mid-CONV (cycle 15) -> all outputs 0 immediately. After release, a fresh conversion of 42 -> bcd=12'h042.
- out_ready held high across back-to-back inputs 1, 2, 3 -> each result 12'h001/002/003 appears with out_valid high for one cycle. Spacing is DATA_W+2 cycles.
